multicycle_ctrl: RTL and testbench

Parametrised multicycle control FSM for the ARM32 datapath, and the next generation of the current fixed-sequence controller. It sequences fetch, decode, execute, ALU, memory and write-back, and handshakes with RAM through `mem_ready` plus a configurable minimum wait count. It evaluates ARM condition codes against NZCV, and adds load/store, halt and retire signalling. It drives the datapath register enables, operand muxes, regfile write and RAM address/write strobes.

---
 rtl/multicycle_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// multicycle_ctrl : multicycle ARM32 control FSM with RAM ready/wait handshake.
// Optional macro COND_EXEC_EN enables ARM condition-code evaluation.
// Rev 1.0
// ============================================================================
module multicycle_ctrl #(
  parameter int MEM_WAIT = 1,
  parameter int ALU_OP_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          opcode,
  input  logic [3:0]          cond,
  input  logic [31:0]         status_reg,
  input  logic                mem_ready,
  output logic                waiting,
  output logic                wb_sel,
  output logic                sel_A,
  output logic                sel_B,
  output logic                sel_shift,
  output logic                w_en1,
  output logic                en_A,
  output logic                en_B,
  output logic                en_C,
  output logic                en_S,
  output logic                en_status,
  output logic [ALU_OP_W-1:0] ALU_op,
  output logic                load_ir,
  output logic                load_pc,
  output logic                load_addr,
  output logic                sel_addr,
  output logic                ram_w_en,
  output logic                halted,
  output logic                retire
);

  typedef enum logic [3:0] {
    ST_RESET      = 4'd0,
    ST_FETCH      = 4'd1,
    ST_FETCH_WAIT = 4'd2,
    ST_DECODE     = 4'd3,
    ST_EXECUTE    = 4'd4,
    ST_ALU        = 4'd5,
    ST_MEMORY     = 4'd6,
    ST_MEM_WAIT   = 4'd7,
    ST_WRITE_BACK = 4'd8,
    ST_HALT       = 4'd9
  } state_t;

  localparam logic [ALU_OP_W-1:0] OP_ADD = ALU_OP_W'(3'b000);
  localparam logic [ALU_OP_W-1:0] OP_SUB = ALU_OP_W'(3'b001);
  localparam logic [ALU_OP_W-1:0] OP_AND = ALU_OP_W'(3'b010);
  localparam logic [ALU_OP_W-1:0] OP_ORR = ALU_OP_W'(3'b011);
  localparam logic [ALU_OP_W-1:0] OP_XOR = ALU_OP_W'(3'b111);

  state_t     state;
  state_t     state_nx;
  logic [3:0] wait_cnt;
  logic       wb_retire;

  logic is_ls, is_str, is_ldr, is_dp, is_cmp, is_hlt, is_nop;
  logic cond_ok, skip, mem_done;
  logic [ALU_OP_W-1:0] alu_code;
  logic unused_status;

  assign is_ls    = opcode[6];
  assign is_str   = opcode[6:5] == 2'b10;
  assign is_ldr   = opcode[6:5] == 2'b11;
  assign is_dp    = ~opcode[6];
  assign is_cmp   = is_dp && (opcode[3:0] == 4'b1010);
  assign is_hlt   = opcode == 7'b0000001;
  assign is_nop   = opcode == 7'b0000000;
  assign mem_done = (wait_cnt == 4'd0) && mem_ready;

`ifdef COND_EXEC_EN
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] nzcv);
    logic n, z, cf, v;
    n  = nzcv[3];
    z  = nzcv[2];
    cf = nzcv[1];
    v  = nzcv[0];
    case (c)
      4'h0:    return z;
      4'h1:    return !z;
      4'h2:    return cf;
      4'h3:    return !cf;
      4'h4:    return n;
      4'h5:    return !n;
      4'h6:    return v;
      4'h7:    return !v;
      4'h8:    return cf && !z;
      4'h9:    return !cf || z;
      4'hA:    return n == v;
      4'hB:    return n != v;
      4'hC:    return !z && (n == v);
      4'hD:    return z || (n != v);
      4'hE:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign cond_ok       = cond_pass(cond, status_reg[31:28]);
  assign unused_status = ^status_reg[27:0];
`else
  assign cond_ok       = 1'b1;
  assign unused_status = ^status_reg;
`endif

  assign skip = is_nop || (cond == 4'hF) || !cond_ok;

  always_comb begin
    alu_code = OP_ADD;
    if (is_dp) begin
      case (opcode[2:0])
        3'b000:         alu_code = OP_ADD;
        3'b001, 3'b010: alu_code = OP_SUB;
        3'b011:         alu_code = OP_AND;
        3'b100:         alu_code = OP_ORR;
        3'b101:         alu_code = OP_XOR;
        default:        alu_code = OP_ADD;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_RESET:      state_nx = ST_FETCH;
      ST_FETCH:      state_nx = ST_FETCH_WAIT;
      ST_FETCH_WAIT: if (mem_ready) state_nx = ST_DECODE;
      ST_DECODE: begin
        if (is_hlt)    state_nx = ST_HALT;
        else if (skip) state_nx = ST_FETCH;
        else           state_nx = ST_EXECUTE;
      end
      ST_EXECUTE:    state_nx = ST_ALU;
      ST_ALU:        state_nx = is_ls ? ST_MEMORY : ST_WRITE_BACK;
      ST_MEMORY:     state_nx = ST_MEM_WAIT;
      ST_MEM_WAIT:   if (mem_done) state_nx = is_str ? ST_FETCH : ST_WRITE_BACK;
      ST_WRITE_BACK: state_nx = ST_FETCH;
      ST_HALT:       state_nx = ST_HALT;
      default:       state_nx = ST_RESET;
    endcase
  end

  // Outputs are registered from the next state so they are valid for the whole state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RESET;
      wait_cnt  <= 4'd0;
      waiting   <= 1'b1;
      wb_sel    <= 1'b0;
      sel_A     <= 1'b0;
      sel_B     <= 1'b0;
      sel_shift <= 1'b0;
      w_en1     <= 1'b0;
      en_A      <= 1'b0;
      en_B      <= 1'b0;
      en_C      <= 1'b0;
      en_S      <= 1'b0;
      en_status <= 1'b0;
      ALU_op    <= '0;
      load_addr <= 1'b0;
      sel_addr  <= 1'b0;
      ram_w_en  <= 1'b0;
      halted    <= 1'b0;
      wb_retire <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_MEMORY)
        wait_cnt <= 4'(MEM_WAIT);
      else if ((state == ST_MEM_WAIT) && (wait_cnt != 4'd0))
        wait_cnt <= wait_cnt - 4'd1;

      waiting   <= state_nx inside {ST_RESET, ST_FETCH, ST_FETCH_WAIT,
                                    ST_DECODE, ST_MEM_WAIT, ST_HALT};
      en_A      <= (state_nx == ST_EXECUTE) && (is_ls || opcode[3]);
      en_B      <= (state_nx == ST_EXECUTE) && (is_ls || opcode[4]);
      en_S      <= (state_nx == ST_EXECUTE) && is_dp && opcode[4];
      sel_shift <= (state_nx == ST_EXECUTE) && is_dp && opcode[5];
      en_C      <= state_nx == ST_ALU;
      sel_A     <= (state_nx == ST_ALU) && is_dp && !opcode[3];
      sel_B     <= (state_nx == ST_ALU) && is_dp && !opcode[4];
      en_status <= (state_nx == ST_ALU) && is_cmp;
      ALU_op    <= (state_nx == ST_ALU) ? alu_code : '0;
      load_addr <= (state_nx == ST_FETCH) || (state_nx == ST_MEMORY);
      sel_addr  <= state_nx == ST_MEMORY;
      ram_w_en  <= (state_nx == ST_MEMORY) && is_str;
      wb_sel    <= (state_nx == ST_WRITE_BACK) && is_ldr;
      w_en1     <= (state_nx == ST_WRITE_BACK) && !is_cmp;
      wb_retire <= state_nx == ST_WRITE_BACK;
      halted    <= state_nx == ST_HALT;
    end
  end

  // Handshake-qualified strobes must land in the same cycle the input is seen.
  assign load_ir = (state == ST_FETCH_WAIT) && mem_ready;
  assign load_pc = load_ir;
  assign retire  = wb_retire
                 || ((state == ST_DECODE) && !is_hlt && skip)
                 || ((state == ST_MEM_WAIT) && mem_done && is_str);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// Directed testbench for multicycle_ctrl (MEM_WAIT=3).
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = 7'b0011000;
  logic [3:0]  cond = 4'hE;
  logic [31:0] status_reg = 32'h0;
  logic        mem_ready = 1'b1;
  logic waiting, wb_sel, sel_A, sel_B, sel_shift, w_en1;
  logic en_A, en_B, en_C, en_S, en_status;
  logic [2:0] ALU_op;
  logic load_ir, load_pc, load_addr, sel_addr, ram_w_en, halted, retire;

  int errors = 0;
  int checks = 0;

  logic [2:0]  exp_op [8]   = '{3'b000, 3'b001, 3'b001, 3'b010, 3'b011, 3'b111, 3'b000, 3'b000};
  logic [3:0]  sk_cond [7]  = '{4'h0, 4'h0, 4'hC, 4'h8, 4'h9, 4'hA, 4'hF};
  logic [31:0] sk_stat [7]  = '{32'h0, 32'h4000_0000, 32'h8000_0000, 32'h2000_0000,
                                32'h2000_0000, 32'h9000_0000, 32'h0};
  logic        sk_en [7]    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic        sk_dis [7]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  multicycle_ctrl #(.MEM_WAIT(3), .ALU_OP_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .cond(cond), .status_reg(status_reg),
    .mem_ready(mem_ready), .waiting(waiting), .wb_sel(wb_sel), .sel_A(sel_A), .sel_B(sel_B),
    .sel_shift(sel_shift), .w_en1(w_en1), .en_A(en_A), .en_B(en_B), .en_C(en_C), .en_S(en_S),
    .en_status(en_status), .ALU_op(ALU_op), .load_ir(load_ir), .load_pc(load_pc),
    .load_addr(load_addr), .sel_addr(sel_addr), .ram_w_en(ram_w_en), .halted(halted),
    .retire(retire)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (waiting !== 1'b1)   begin errors++; $display("FAIL rst_waiting: got %b want 1", waiting); end
    checks++; if (load_addr !== 1'b0) begin errors++; $display("FAIL rst_load_addr: got %b want 0", load_addr); end
    checks++; if (retire !== 1'b0)    begin errors++; $display("FAIL rst_retire: got %b want 0", retire); end
    checks++; if (halted !== 1'b0)    begin errors++; $display("FAIL rst_halted: got %b want 0", halted); end
    checks++; if (ALU_op !== 3'b000)  begin errors++; $display("FAIL rst_alu_op: got %b want 000", ALU_op); end
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (load_addr !== 1'b0) begin errors++; $display("FAIL rst_release_early: got %b want 0", load_addr); end
    tick;
    checks++; if (load_addr !== 1'b1) begin errors++; $display("FAIL rst_first_fetch: got %b want 1", load_addr); end
    checks++; if (sel_addr !== 1'b0)  begin errors++; $display("FAIL rst_fetch_sel_addr: got %b want 0", sel_addr); end
  endtask

  task automatic test_add;
    opcode = 7'b0011000; cond = 4'hE; mem_ready = 1'b1;
    tick;
    checks++; if (load_ir !== 1'b1 || load_pc !== 1'b1) begin errors++; $display("FAIL add_load_ir: got %b%b want 11", load_ir, load_pc); end
    tick;
    checks++; if (en_A !== 1'b0 || retire !== 1'b0) begin errors++; $display("FAIL add_decode: en_A=%b retire=%b want 0 0", en_A, retire); end
    tick;
    checks++; if ({en_A, en_B, en_S, sel_shift, waiting} !== 5'b11100) begin errors++; $display("FAIL add_execute: got %b want 11100", {en_A, en_B, en_S, sel_shift, waiting}); end
    tick;
    checks++; if (ALU_op !== 3'b000 || en_C !== 1'b1) begin errors++; $display("FAIL add_alu: op=%b en_C=%b want 000 1", ALU_op, en_C); end
    checks++; if ({sel_A, sel_B, en_status} !== 3'b000) begin errors++; $display("FAIL add_alu_sel: got %b want 000", {sel_A, sel_B, en_status}); end
    tick;
    checks++; if ({w_en1, retire, wb_sel} !== 3'b110) begin errors++; $display("FAIL add_wb: got %b want 110", {w_en1, retire, wb_sel}); end
    tick;
    checks++; if (load_addr !== 1'b1 || retire !== 1'b0) begin errors++; $display("FAIL add_refetch: load_addr=%b retire=%b want 1 0", load_addr, retire); end
  endtask

  task automatic test_cmp;
    opcode = 7'b0011010;
    repeat (4) tick;
    checks++; if (en_status !== 1'b1 || ALU_op !== 3'b001) begin errors++; $display("FAIL cmp_alu: en_status=%b op=%b want 1 001", en_status, ALU_op); end
    tick;
    checks++; if (w_en1 !== 1'b0 || retire !== 1'b1) begin errors++; $display("FAIL cmp_wb: w_en1=%b retire=%b want 0 1", w_en1, retire); end
    tick;
  endtask

  task automatic test_alu_ops;
    for (int f = 0; f < 8; f++) begin
      opcode = {3'b011, 1'b1, 3'(f)};
      repeat (3) tick;
      checks++; if (sel_shift !== 1'b1) begin errors++; $display("FAIL aluop%0d_shift: got %b want 1", f, sel_shift); end
      tick;
      checks++; if (ALU_op !== exp_op[f]) begin errors++; $display("FAIL aluop%0d: got %b want %b", f, ALU_op, exp_op[f]); end
      checks++; if (en_status !== (f == 2)) begin errors++; $display("FAIL aluop%0d_status: got %b want %b", f, en_status, f == 2); end
      repeat (2) tick;
    end
    opcode = 7'b0000100;
    repeat (3) tick;
    checks++; if (en_A !== 1'b0 || en_B !== 1'b0) begin errors++; $display("FAIL imm_execute: en_A=%b en_B=%b want 0 0", en_A, en_B); end
    tick;
    checks++; if ({sel_A, sel_B, ALU_op} !== 5'b11011) begin errors++; $display("FAIL imm_alu: got %b want 11011", {sel_A, sel_B, ALU_op}); end
    repeat (2) tick;
  endtask

  task automatic test_skip;
    logic exp_skip;
    opcode = 7'b0000000; cond = 4'hE;
    repeat (2) tick;
    checks++; if (retire !== 1'b1) begin errors++; $display("FAIL nop_retire: got %b want 1", retire); end
    tick;
    checks++; if (load_addr !== 1'b1) begin errors++; $display("FAIL nop_refetch: got %b want 1", load_addr); end
    opcode = 7'b0011000;
    for (int i = 0; i < 7; i++) begin
`ifdef COND_EXEC_EN
      exp_skip = sk_en[i];
`else
      exp_skip = sk_dis[i];
`endif
      cond = sk_cond[i]; status_reg = sk_stat[i];
      repeat (2) tick;
      checks++; if (retire !== exp_skip) begin errors++; $display("FAIL skip%0d_decode_retire: got %b want %b", i, retire, exp_skip); end
      tick;
      if (exp_skip) begin
        checks++; if (load_addr !== 1'b1 || en_A !== 1'b0) begin errors++; $display("FAIL skip%0d_refetch: load_addr=%b en_A=%b want 1 0", i, load_addr, en_A); end
      end else begin
        checks++; if (en_A !== 1'b1) begin errors++; $display("FAIL skip%0d_exec: en_A=%b want 1", i, en_A); end
        repeat (2) tick;
        checks++; if (retire !== 1'b1) begin errors++; $display("FAIL skip%0d_wb_retire: got %b want 1", i, retire); end
        tick;
      end
    end
    cond = 4'hE; status_reg = 32'h0;
  endtask

  task automatic test_str;
    int n;
    opcode = 7'b1000000; mem_ready = 1'b1;
    repeat (3) tick;
    checks++; if ({en_A, en_B, en_S} !== 3'b110) begin errors++; $display("FAIL str_execute: got %b want 110", {en_A, en_B, en_S}); end
    tick;
    checks++; if ({ALU_op, en_C, sel_A, sel_B} !== 6'b000100) begin errors++; $display("FAIL str_alu: got %b want 000100", {ALU_op, en_C, sel_A, sel_B}); end
    tick;
    checks++; if ({load_addr, sel_addr, ram_w_en, waiting} !== 4'b1110) begin errors++; $display("FAIL str_memory: got %b want 1110", {load_addr, sel_addr, ram_w_en, waiting}); end
    tick;
    checks++; if (ram_w_en !== 1'b0 || waiting !== 1'b1) begin errors++; $display("FAIL str_memwait: ram_w_en=%b waiting=%b want 0 1", ram_w_en, waiting); end
    n = 1;
    while (retire !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL str_wait_cycles: got %0d want 4", n); end
    tick;
    checks++; if (load_addr !== 1'b1 || sel_addr !== 1'b0 || retire !== 1'b0) begin errors++; $display("FAIL str_refetch: got %b%b%b want 100", load_addr, sel_addr, retire); end
  endtask

  task automatic test_ldr;
    opcode = 7'b1100000; mem_ready = 1'b1;
    repeat (2) tick;
    mem_ready = 1'b0;
    repeat (3) tick;
    checks++; if (ram_w_en !== 1'b0 || load_addr !== 1'b1) begin errors++; $display("FAIL ldr_memory: ram_w_en=%b load_addr=%b want 0 1", ram_w_en, load_addr); end
    repeat (2) tick;
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    checks++; if (waiting !== 1'b1 || wb_sel !== 1'b0) begin errors++; $display("FAIL ldr_early_ready: waiting=%b wb_sel=%b want 1 0", waiting, wb_sel); end
    tick;
    checks++; if (waiting !== 1'b1) begin errors++; $display("FAIL ldr_cnt0_not_ready: got %b want 1", waiting); end
    tick;
    mem_ready = 1'b1;
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL ldr_memwait_retire: got %b want 0", retire); end
    tick;
    checks++; if ({wb_sel, w_en1, retire, waiting} !== 4'b1110) begin errors++; $display("FAIL ldr_wb: got %b want 1110", {wb_sel, w_en1, retire, waiting}); end
    tick;
  endtask

  task automatic test_reset_mid;
    opcode = 7'b1000000; mem_ready = 1'b1;
    repeat (2) tick;
    mem_ready = 1'b0;
    repeat (5) tick;
    rst_n = 1'b0;
    #1;
    checks++; if (waiting !== 1'b1 || ram_w_en !== 1'b0 || load_addr !== 1'b0) begin errors++; $display("FAIL midrst_async: got %b%b%b want 100", waiting, ram_w_en, load_addr); end
    tick;
    checks++; if (waiting !== 1'b1 || sel_addr !== 1'b0) begin errors++; $display("FAIL midrst_held: waiting=%b sel_addr=%b want 1 0", waiting, sel_addr); end
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1;
    tick;
    checks++; if (load_addr !== 1'b1) begin errors++; $display("FAIL midrst_refetch: got %b want 1", load_addr); end
  endtask

  task automatic test_halt;
    int bad;
    opcode = 7'b0000001;
    repeat (2) tick;
    checks++; if (retire !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL hlt_decode: retire=%b halted=%b want 0 0", retire, halted); end
    tick;
    checks++; if (halted !== 1'b1 || waiting !== 1'b1) begin errors++; $display("FAIL hlt_enter: halted=%b waiting=%b want 1 1", halted, waiting); end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      tick;
      if (halted !== 1'b1 || retire !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL hlt_hold: bad cycles %0d want 0", bad); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_cmp;
    test_alu_ops;
    test_skip;
    test_str;
    test_ldr;
    test_reset_mid;
    test_halt;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
